// File: rtl/stg_ma_np_if.sv
// stg_ma_np_if: memory-port bundle of the stg_ma_np stage.
// The stage is the master. It drives the phase counter, the one-hot request, the
// write strobe, the per-port addresses and the shared store data.
// The memory side is the slave. It returns per-port acknowledges and read data.
interface stg_ma_np_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 24,
    parameter int NPORTS = 2,
    parameter int MP_W   = 1
);
    logic [MP_W-1:0]          ow_mem_mp;
    logic [NPORTS-1:0]        ow_mem_req;
    logic                     ow_mem_we;
    logic [NPORTS*ADDR_W-1:0] ow_mem_addr;
    logic [DATA_W-1:0]        ow_mem_wdata;
    logic [NPORTS-1:0]        iw_mem_ack;
    logic [NPORTS*DATA_W-1:0] iw_mem_rdata;

    modport master (
        output ow_mem_mp,
        output ow_mem_req,
        output ow_mem_we,
        output ow_mem_addr,
        output ow_mem_wdata,
        input  iw_mem_ack,
        input  iw_mem_rdata
    );

    modport slave (
        input  ow_mem_mp,
        input  ow_mem_req,
        input  ow_mem_we,
        input  ow_mem_addr,
        input  ow_mem_wdata,
        output iw_mem_ack,
        output iw_mem_rdata
    );
endinterface

// File: rtl/stg_ma_np.sv
// stg_ma_np: parametrised memory-access pipeline stage between execute and write-back.
//
// Overview:
// - NPORTS memory ports are time-multiplexed by a free-running phase counter.
// - A memory op is bound to the port whose phase is current when it is accepted.
// - At most one request is outstanding at a time.
// - Upstream is stalled while that request waits for its acknowledge.
// - All sideband signals toward write-back are registered.
//
// Optional feature (macro STG_MA_NP_TIMEOUT_EN):
// - Adds an ack timeout after TIMEOUT_CYC cycles.
// - A timed-out request retires as a faulted bubble on ow_fault.
module stg_ma_np #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 24,
    parameter int OPC_W       = 8,
    parameter int TGT_GP_W    = 4,
    parameter int TGT_SR_W    = 2,
    parameter int NPORTS      = 2,
    parameter int MP_W        = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                iw_clk,
    input  logic                iw_rst,
    input  logic                iw_valid,
    input  logic [ADDR_W-1:0]   iw_pc,
    input  logic [DATA_W-1:0]   iw_instr,
    input  logic [OPC_W-1:0]    iw_opc,
    input  logic [TGT_GP_W-1:0] iw_tgt_gp,
    input  logic                iw_tgt_gp_we,
    input  logic [TGT_SR_W-1:0] iw_tgt_sr,
    input  logic                iw_tgt_sr_we,
    input  logic                iw_mem_rd,
    input  logic                iw_mem_wr,
    input  logic [ADDR_W-1:0]   iw_addr,
    input  logic [DATA_W-1:0]   iw_result,
    output logic                ow_stall,
    output logic                ow_valid,
    output logic [ADDR_W-1:0]   ow_pc,
    output logic [DATA_W-1:0]   ow_instr,
    output logic [OPC_W-1:0]    ow_opc,
    output logic [TGT_GP_W-1:0] ow_tgt_gp,
    output logic                ow_tgt_gp_we,
    output logic [TGT_SR_W-1:0] ow_tgt_sr,
    output logic                ow_tgt_sr_we,
    output logic [DATA_W-1:0]   ow_result,
`ifdef STG_MA_NP_TIMEOUT_EN
    output logic                ow_fault,
`endif
    stg_ma_np_if.master         mem
);

    // Reject configurations where the phase counter cannot reach every port.
    if (NPORTS < 1 || (2 ** MP_W) < NPORTS || TIMEOUT_CYC < 1) begin : g_param_check
        $error("stg_ma_np: need NPORTS>=1, 2**MP_W>=NPORTS and TIMEOUT_CYC>=1");
    end

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_REQ
    } state_t;

    state_t              r_state, n_state;
    logic [MP_W-1:0]     r_mp;
    logic [MP_W-1:0]     r_port, n_port;
    logic                r_store, n_store;
    logic                r_valid, n_valid;
    logic [ADDR_W-1:0]   r_pc, n_pc;
    logic [DATA_W-1:0]   r_instr, n_instr;
    logic [OPC_W-1:0]    r_opc, n_opc;
    logic [TGT_GP_W-1:0] r_tgt_gp, n_tgt_gp;
    logic                r_tgt_gp_we, n_tgt_gp_we;
    logic [TGT_SR_W-1:0] r_tgt_sr, n_tgt_sr;
    logic                r_tgt_sr_we, n_tgt_sr_we;
    logic [DATA_W-1:0]   r_result, n_result;
    logic [NPORTS-1:0]   r_req, n_req;
    logic                r_we, n_we;
    logic [ADDR_W-1:0]   r_addr, n_addr;
    logic [DATA_W-1:0]   r_wdata, n_wdata;

    logic [NPORTS-1:0]   phase_onehot;
    logic                ack_sel;
    logic [DATA_W-1:0]   rdata_sel;

`ifdef STG_MA_NP_TIMEOUT_EN
    // The counter only has to count 0..TIMEOUT_CYC-1.
    localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WAIT_W-1:0]   r_wait, n_wait;
    logic                r_fault, n_fault;
`endif

    // The phase counter runs freely, even while stalled, and wraps at NPORTS-1.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_mp <= '0;
        end else if (r_mp == MP_W'(NPORTS - 1)) begin
            r_mp <= '0;
        end else begin
            r_mp <= r_mp + MP_W'(1);
        end
    end

    // Decode the current phase into a one-hot request.
    // Select the ack and read data of the port that owns the outstanding request.
    always_comb begin
        phase_onehot = '0;
        ack_sel      = 1'b0;
        rdata_sel    = '0;
        for (int p = 0; p < NPORTS; p++) begin
            phase_onehot[p] = (r_mp == MP_W'(p));
            if (r_port == MP_W'(p)) begin
                ack_sel   = mem.iw_mem_ack[p];
                rdata_sel = mem.iw_mem_rdata[p*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic: accept in IDLE, wait for the bound port's ack in REQ.
    always_comb begin
        n_state     = r_state;
        n_port      = r_port;
        n_store     = r_store;
        n_valid     = 1'b0;
        n_pc        = r_pc;
        n_instr     = r_instr;
        n_opc       = r_opc;
        n_tgt_gp    = r_tgt_gp;
        n_tgt_gp_we = r_tgt_gp_we;
        n_tgt_sr    = r_tgt_sr;
        n_tgt_sr_we = r_tgt_sr_we;
        n_result    = r_result;
        n_req       = r_req;
        n_we        = r_we;
        n_addr      = r_addr;
        n_wdata     = r_wdata;
`ifdef STG_MA_NP_TIMEOUT_EN
        n_wait      = r_wait;
        n_fault     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (iw_valid) begin
                    n_pc        = iw_pc;
                    n_instr     = iw_instr;
                    n_opc       = iw_opc;
                    n_tgt_gp    = iw_tgt_gp;
                    n_tgt_gp_we = iw_tgt_gp_we;
                    n_tgt_sr    = iw_tgt_sr;
                    n_tgt_sr_we = iw_tgt_sr_we;
                    if (iw_mem_rd || iw_mem_wr) begin
                        // A store wins when both rd and wr are set, so its rdata is never used.
                        n_state = ST_REQ;
                        n_port  = r_mp;
                        n_store = iw_mem_wr;
                        n_req   = phase_onehot;
                        n_we    = iw_mem_wr;
                        n_addr  = iw_addr;
                        n_wdata = iw_result;
`ifdef STG_MA_NP_TIMEOUT_EN
                        n_wait  = '0;
`endif
                    end else begin
                        n_valid  = 1'b1;
                        n_result = iw_result;
                    end
                end
            end
            ST_REQ: begin
                if (ack_sel) begin
                    n_state  = ST_IDLE;
                    n_req    = '0;
                    n_we     = 1'b0;
                    n_valid  = 1'b1;
                    n_result = r_store ? r_wdata : rdata_sel;
                end
`ifdef STG_MA_NP_TIMEOUT_EN
                else if (r_wait == WAIT_W'(TIMEOUT_CYC - 1)) begin
                    n_state     = ST_IDLE;
                    n_req       = '0;
                    n_we        = 1'b0;
                    n_valid     = 1'b1;
                    n_fault     = 1'b1;
                    n_tgt_gp_we = 1'b0;
                    n_tgt_sr_we = 1'b0;
                    n_result    = '0;
                end else begin
                    n_wait = r_wait + WAIT_W'(1);
                end
`endif
            end
            default: begin
                n_state = ST_IDLE;
            end
        endcase
    end

    // State and pipeline register bank; reset drops any outstanding request without a write-back.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_state     <= ST_IDLE;
            r_port      <= '0;
            r_store     <= 1'b0;
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_instr     <= '0;
            r_opc       <= '0;
            r_tgt_gp    <= '0;
            r_tgt_gp_we <= 1'b0;
            r_tgt_sr    <= '0;
            r_tgt_sr_we <= 1'b0;
            r_result    <= '0;
            r_req       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
`ifdef STG_MA_NP_TIMEOUT_EN
            r_wait      <= '0;
            r_fault     <= 1'b0;
`endif
        end else begin
            r_state     <= n_state;
            r_port      <= n_port;
            r_store     <= n_store;
            r_valid     <= n_valid;
            r_pc        <= n_pc;
            r_instr     <= n_instr;
            r_opc       <= n_opc;
            r_tgt_gp    <= n_tgt_gp;
            r_tgt_gp_we <= n_tgt_gp_we;
            r_tgt_sr    <= n_tgt_sr;
            r_tgt_sr_we <= n_tgt_sr_we;
            r_result    <= n_result;
            r_req       <= n_req;
            r_we        <= n_we;
            r_addr      <= n_addr;
            r_wdata     <= n_wdata;
`ifdef STG_MA_NP_TIMEOUT_EN
            r_wait      <= n_wait;
            r_fault     <= n_fault;
`endif
        end
    end

    // Fan the single captured address out to the requesting port only.
    // Every other slice reads 0.
    always_comb begin
        mem.ow_mem_addr = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (r_req[p]) begin
                mem.ow_mem_addr[p*ADDR_W +: ADDR_W] = r_addr;
            end
        end
    end

    assign mem.ow_mem_mp    = r_mp;
    assign mem.ow_mem_req   = r_req;
    assign mem.ow_mem_we    = r_we;
    assign mem.ow_mem_wdata = r_wdata;

    assign ow_stall     = (r_state == ST_REQ);
    assign ow_valid     = r_valid;
    assign ow_pc        = r_pc;
    assign ow_instr     = r_instr;
    assign ow_opc       = r_opc;
    assign ow_tgt_gp    = r_tgt_gp;
    assign ow_tgt_gp_we = r_tgt_gp_we;
    assign ow_tgt_sr    = r_tgt_sr;
    assign ow_tgt_sr_we = r_tgt_sr_we;
    assign ow_result    = r_result;
`ifdef STG_MA_NP_TIMEOUT_EN
    assign ow_fault     = r_fault;
`endif

endmodule
